// File: rtl/mdr_mem_ctrl_pkg.sv
// mdr_ctrl_pkg: shared types and constants for the MDR input-path sequencer.
//   state_e         - sequencer states, also exported on the debug state port
//   TIMEOUT_DEFAULT - default bound on cycles spent waiting for mem_ready
package mdr_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_LATCH,
        WR_WAIT,
        LD,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/mdr_mem_ctrl_if.sv
// mdr_mem_ctrl_if: control-unit requests, memory handshake and MDR controls.
//   Requests (rd_req/wr_req/ld_req) are levels held by the control unit until
//   done (or err for memory operations). mem_ready is sampled only in the wait
//   states; high means read data valid or write accepted. All sequencer
//   outputs are decoded from registered state.
//   slave  : the sequencer side (mdr_mem_ctrl)
//   master : the control unit / memory side
//   state  : debug view of the sequencer state
interface mdr_mem_ctrl_if;
    import mdr_ctrl_pkg::*;

    logic   rd_req;
    logic   wr_req;
    logic   ld_req;
    logic   mem_ready;
    logic   mem_rd;
    logic   mem_wr;
    logic   mdr_read_sel;
    logic   mdr_in;
    logic   busy;
    logic   done;
    logic   err;
    state_e state;

    modport slave (
        input  rd_req, wr_req, ld_req, mem_ready,
        output mem_rd, mem_wr, mdr_read_sel, mdr_in, busy, done, err, state
    );

    modport master (
        output rd_req, wr_req, ld_req, mem_ready,
        input  mem_rd, mem_wr, mdr_read_sel, mdr_in, busy, done, err, state
    );

endinterface

// File: rtl/mdr_mem_ctrl_wait_timer.sv
// wait_timer: clearable, saturating cycle counter for the memory wait states.
//   clk, clr : clock, asynchronous active-low reset
//   clr_cnt  : synchronous clear (wins over en)
//   en       : count one cycle
//   expired  : count has reached TIMEOUT-1, i.e. this is the last wait cycle
module wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic clr,
    input  logic clr_cnt,
    input  logic en,
    output logic expired
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_cnt) begin
            count_d = '0;
        end else if (en && (count_q != CW'(TIMEOUT))) begin
            // Saturate at TIMEOUT so the counter can never wrap back to 0.
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl: Moore sequencer for the MDR input path.
//   clk : system clock, rising edge
//   clr : asynchronous active-low reset
//   bus : mdr_mem_ctrl_if.slave - requests, mem_ready in; mem_rd, mem_wr,
//         mdr_read_sel, mdr_in, busy, done, err, debug state out
// Reads go RD_WAIT -> RD_LATCH -> DONE, writes WR_WAIT -> DONE, bus loads
// LD -> DONE; a wait state that sees no mem_ready for TIMEOUT cycles goes to
// ERR. Priority in IDLE is read > write > load.
module mdr_mem_ctrl
    import mdr_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic           clk,
    input  logic           clr,
    mdr_mem_ctrl_if.slave  bus
);

    state_e state_q, state_d;
    logic   armed_q, armed_d;
    logic   in_wait;
    logic   expired;

    // The first edge after reset release only arms the sequencer; requests
    // are accepted from the second edge on.
    assign armed_d = 1'b1;
    assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    // Counter is held clear outside the wait states, so it is 0 on entry.
    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_wait_timer (
        .clk     (clk),
        .clr     (clr),
        .clr_cnt (!in_wait),
        .en      (in_wait),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (armed_q) begin
                    if (bus.rd_req)      state_d = RD_WAIT;
                    else if (bus.wr_req) state_d = WR_WAIT;
                    else if (bus.ld_req) state_d = LD;
                end
            end
            // mem_ready is checked first so it wins over a same-cycle timeout.
            RD_WAIT: begin
                if (bus.mem_ready)   state_d = RD_LATCH;
                else if (expired)    state_d = ERR;
            end
            WR_WAIT: begin
                if (bus.mem_ready)   state_d = DONE;
                else if (expired)    state_d = ERR;
            end
            RD_LATCH: state_d = DONE;
            LD:       state_d = DONE;
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

    assign bus.mem_rd       = (state_q == RD_WAIT);
    assign bus.mem_wr       = (state_q == WR_WAIT);
    assign bus.mdr_read_sel = (state_q == RD_LATCH);
    assign bus.mdr_in       = (state_q == RD_LATCH) || (state_q == LD);
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.err          = (state_q == ERR);
    assign bus.state        = state_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb_mdr_mem_ctrl: directed bench for mdr_mem_ctrl with TIMEOUT=4. A small
// MDR register and 2:1 mux live here so the loaded data can be checked.
module tb_mdr_mem_ctrl;
  import mdr_ctrl_pkg::*;

  // {mem_rd, mem_wr, mdr_read_sel, mdr_in, busy, done, err}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_RDW   = 7'b1000100;
  localparam logic [6:0] O_LATCH = 7'b0011100;
  localparam logic [6:0] O_WRW   = 7'b0100100;
  localparam logic [6:0] O_LD    = 7'b0001100;
  localparam logic [6:0] O_DONE  = 7'b0000110;
  localparam logic [6:0] O_ERR   = 7'b0000101;

  // clock / reset
  logic clk;
  logic clr;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mdr_mem_ctrl_if mif ();

  mdr_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (mif)
  );

  // MDR and its input mux, outside the block under test
  logic [31:0] mdatain;
  logic [31:0] bus_mux_out;
  logic [31:0] mdr;
  initial mdr = 32'h0;
  always @(posedge clk) begin
    if (mif.mdr_in) mdr <= mif.mdr_read_sel ? mdatain : bus_mux_out;
  end

  logic [6:0] outs;
  assign outs = {mif.mem_rd, mif.mem_wr, mif.mdr_read_sel, mif.mdr_in,
                 mif.busy, mif.done, mif.err};

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: advance one clock, land 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0;
    mif.rd_req = 1'b1;
    mif.wr_req = 1'b1;
    mif.ld_req = 1'b1;
    mif.mem_ready = 1'b1;
    mdatain = 32'h0000_0010;
    bus_mux_out = 32'h0000_0001;

    // reset held with all requests high
    step();
    step();
    chk("rst_outs", 32'(outs), 32'(O_IDLE));
    chk("rst_state", 32'(mif.state), 32'(IDLE));

    // release between edges: first edge idle, second accepts the read
    #3 clr = 1'b1;
    step();
    chk("rel_edge1", 32'(outs), 32'(O_IDLE));
    step();
    chk("pri_rd_accept", 32'(outs), 32'(O_RDW));
    step();
    chk("rd_latch", 32'(outs), 32'(O_LATCH));
    step();
    chk("rd_done", 32'(outs), 32'(O_DONE));
    chk("rd_mdr", mdr, 32'h0000_0010);
    mif.rd_req = 1'b0;

    // write then load still held, each after one IDLE cycle
    step();
    chk("gap_rd_wr", 32'(outs), 32'(O_IDLE));
    step();
    chk("pri_wr", 32'(outs), 32'(O_WRW));
    step();
    chk("wr0_done", 32'(outs), 32'(O_DONE));
    mif.wr_req = 1'b0;
    step();
    chk("gap_wr_ld", 32'(outs), 32'(O_IDLE));
    step();
    chk("pri_ld", 32'(outs), 32'(O_LD));
    step();
    chk("ld_done", 32'(outs), 32'(O_DONE));
    chk("ld_mdr", mdr, 32'h0000_0001);
    mif.ld_req = 1'b0;
    step();
    chk("ld_idle", 32'(outs), 32'(O_IDLE));

    // write with mem_ready arriving in the 4th wait cycle
    mif.mem_ready = 1'b0;
    mif.wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("wr_wait%0d", i), 32'(outs), 32'(O_WRW));
    end
    mif.mem_ready = 1'b1;
    step();
    chk("wr_done", 32'(outs), 32'(O_DONE));
    mif.wr_req = 1'b0;
    mif.mem_ready = 1'b0;
    step();
    chk("wr_busy_low", 32'(mif.busy), 32'h0);
    chk("wr_idle", 32'(outs), 32'(O_IDLE));

    // read timeout: 4 strobe cycles then err, MDR untouched
    mdatain = 32'hDEAD_BEEF;
    mif.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("to_wait%0d", i), 32'(outs), 32'(O_RDW));
    end
    step();
    chk("to_err", 32'(outs), 32'(O_ERR));
    chk("to_state", 32'(mif.state), 32'(ERR));
    mif.rd_req = 1'b0;
    step();
    chk("to_idle", 32'(outs), 32'(O_IDLE));
    chk("to_mdr", mdr, 32'h0000_0001);

    // mem_ready in the final wait cycle beats the timeout
    mdatain = 32'h0000_00A5;
    mif.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("late_wait%0d", i), 32'(outs), 32'(O_RDW));
    end
    mif.mem_ready = 1'b1;
    step();
    chk("late_latch", 32'(outs), 32'(O_LATCH));
    step();
    chk("late_done", 32'(outs), 32'(O_DONE));
    chk("late_mdr", mdr, 32'h0000_00A5);
    mif.rd_req = 1'b0;
    mif.mem_ready = 1'b0;
    step();
    chk("late_idle", 32'(outs), 32'(O_IDLE));

    // clr mid-write drops strobes at once, no done/err
    mif.wr_req = 1'b1;
    step();
    chk("clr_pre0", 32'(outs), 32'(O_WRW));
    step();
    chk("clr_pre1", 32'(outs), 32'(O_WRW));
    #2 clr = 1'b0;
    #1;
    chk("clr_async", 32'(outs), 32'(O_IDLE));
    mif.wr_req = 1'b0;
    step();
    chk("clr_hold", 32'(outs), 32'(O_IDLE));
    chk("clr_mdr", mdr, 32'h0000_00A5);

    // recover: load after release, one settling edge first
    mif.ld_req = 1'b1;
    bus_mux_out = 32'h0000_0077;
    #3 clr = 1'b1;
    step();
    chk("rec_edge1", 32'(outs), 32'(O_IDLE));
    step();
    chk("rec_ld", 32'(outs), 32'(O_LD));
    step();
    chk("rec_done", 32'(outs), 32'(O_DONE));
    chk("rec_mdr", mdr, 32'h0000_0077);
    mif.ld_req = 1'b0;
    step();
    chk("rec_idle", 32'(outs), 32'(O_IDLE));

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
